alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters, e.g. the execute stage (port 0) and the branch-compare unit (port 1). Round-robin arbitration with valid/ready handshakes on request and response. Operands are registered into the ALU, and the result is registered back out. Unsupported operation codes are rejected without reaching the ALU.

---
 rtl/alu_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [5:0]        req0_cnt,
    input  logic [DATA_W-1:0] req0_r1,
    input  logic [DATA_W-1:0] req0_r2,
    input  logic [DATA_W-1:0] req0_imm,
    input  logic [3:0]        req0_shamt,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [5:0]        req1_cnt,
    input  logic [DATA_W-1:0] req1_r1,
    input  logic [DATA_W-1:0] req1_r2,
    input  logic [DATA_W-1:0] req1_imm,
    input  logic [3:0]        req1_shamt,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,

    output logic [5:0]        alu_cnt,
    output logic [DATA_W-1:0] alu_r1,
    output logic [DATA_W-1:0] alu_r2,
    output logic [DATA_W-1:0] alu_imm,
    output logic [3:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_out,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_last_grant;
    logic              r_owner;
    logic              r_err;
    logic [DATA_W-1:0] r_result;
    logic [5:0]        r_alu_cnt;
    logic [DATA_W-1:0] r_alu_r1;
    logic [DATA_W-1:0] r_alu_r2;
    logic [DATA_W-1:0] r_alu_imm;
    logic [3:0]        r_alu_shamt;

    logic              w_idle;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              w_sel;
    logic              w_sel_legal;
    logic              w_rsp_ready;
    logic [5:0]        w_sel_cnt;
    logic [DATA_W-1:0] w_sel_r1;
    logic [DATA_W-1:0] w_sel_r2;
    logic [DATA_W-1:0] w_sel_imm;
    logic [3:0]        w_sel_shamt;

    // Operation codes the ALU implements; anything else is bounced with err.
    function automatic logic f_code_legal(input logic [5:0] code);
        case (code)
            6'd1, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd9,
            6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
            6'd27, 6'd28, 6'd29, 6'd30: f_code_legal = 1'b1;
            default:                    f_code_legal = 1'b0;
        endcase
    endfunction

    // Round-robin grant: a lone requester wins, a tie goes to the port not granted last.
    // Reset masks the grant so nobody believes it was accepted in a cycle that is discarded.
    always_comb begin
        w_idle   = (r_state == IDLE) && !rst;
        w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
        w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);
        w_accept = w_grant0 || w_grant1;
        w_sel    = w_grant1;
    end

    // Steer the winning requester's operation toward the ALU input registers.
    always_comb begin
        if (w_sel) begin
            w_sel_cnt   = req1_cnt;
            w_sel_r1    = req1_r1;
            w_sel_r2    = req1_r2;
            w_sel_imm   = req1_imm;
            w_sel_shamt = req1_shamt;
        end else begin
            w_sel_cnt   = req0_cnt;
            w_sel_r1    = req0_r1;
            w_sel_r2    = req0_r2;
            w_sel_imm   = req0_imm;
            w_sel_shamt = req0_shamt;
        end
        w_sel_legal = f_code_legal(w_sel_cnt);
    end

    // Response ready of whichever port owns the operation in flight.
    always_comb begin
        w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;
    end

    // Next state: illegal codes skip EXEC since the ALU result is never used.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_sel_legal ? EXEC : RESP;
                end
            end
            EXEC: w_next_state = RESP;
            RESP: begin
                if (w_rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: capture operands on accept, capture the ALU result after the EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_err        <= 1'b0;
            r_result     <= '0;
            r_alu_cnt    <= '0;
            r_alu_r1     <= '0;
            r_alu_r2     <= '0;
            r_alu_imm    <= '0;
            r_alu_shamt  <= '0;
        end else if (w_accept) begin
            r_alu_r1     <= w_sel_r1;
            r_alu_r2     <= w_sel_r2;
            r_alu_imm    <= w_sel_imm;
            r_alu_shamt  <= w_sel_shamt;
            r_owner      <= w_sel;
            r_last_grant <= w_sel;
            if (w_sel_legal) begin
                r_alu_cnt <= w_sel_cnt;
            end else begin
                r_alu_cnt <= '0;
                r_result  <= '0;
                r_err     <= 1'b1;
            end
        end else if (r_state == EXEC) begin
            r_result <= alu_out;
            r_err    <= 1'b0;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Result and err come straight from registers, so they stay stable while a response stalls.
    assign rsp0_valid = (r_state == RESP) && !r_owner;
    assign rsp1_valid = (r_state == RESP) && r_owner;
    assign rsp0_data  = r_owner ? '0 : r_result;
    assign rsp1_data  = r_owner ? r_result : '0;
    assign rsp0_err   = !r_owner && r_err;
    assign rsp1_err   = r_owner && r_err;

    assign alu_cnt    = r_alu_cnt;
    assign alu_r1     = r_alu_r1;
    assign alu_r2     = r_alu_r2;
    assign alu_imm    = r_alu_imm;
    assign alu_shamt  = r_alu_shamt;

    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [5:0]  req0_cnt, req1_cnt;
    logic [31:0] req0_r1, req0_r2, req0_imm, req1_r1, req1_r2, req1_imm;
    logic [3:0]  req0_shamt, req1_shamt;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, rsp0_err, rsp1_err;
    logic [31:0] rsp0_data, rsp1_data;
    logic [5:0]  alu_cnt;
    logic [31:0] alu_r1, alu_r2, alu_imm, alu_out;
    logic [3:0]  alu_shamt;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    int legal_codes[19] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12, 13, 14, 15, 16, 17, 27, 28, 29, 30};

    // Behavioural ALU standing in for the shared unit.
    function automatic logic [31:0] alu_fn(input logic [5:0] c, input logic [31:0] a, b, im,
                                          input logic [3:0] sh);
        case (c)
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a & b;
            6'd4:    return a | b;
            6'd6:    return a ^ b;
            6'd7:    return a << sh;
            6'd8:    return a >> sh;
            6'd9:    return a + im;
            6'd27:   return {31'd0, a == b};
            6'd28:   return {31'd0, a != b};
            6'd29:   return {31'd0, $signed(a) < $signed(b)};
            6'd30:   return {31'd0, a < b};
            default: return a ^ b ^ im ^ {22'd0, c, sh};
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] c);
        foreach (legal_codes[i]) if (int'(c) == legal_codes[i]) return 1'b1;
        return 1'b0;
    endfunction

    assign alu_out = alu_fn(alu_cnt, alu_r1, alu_r2, alu_imm, alu_shamt);

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cnt(req0_cnt),
        .req0_r1(req0_r1), .req0_r2(req0_r2), .req0_imm(req0_imm), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cnt(req1_cnt),
        .req1_r1(req1_r1), .req1_r2(req1_r2), .req1_imm(req1_imm), .req1_shamt(req1_shamt),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_cnt(alu_cnt), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_imm(alu_imm),
        .alu_shamt(alu_shamt), .alu_out(alu_out), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [5:0] c,
                           input logic [31:0] a, b, im, input logic [3:0] sh);
        if (p == 0) begin
            req0_valid = v; req0_cnt = c; req0_r1 = a; req0_r2 = b; req0_imm = im; req0_shamt = sh;
        end else begin
            req1_valid = v; req1_cnt = c; req1_r1 = a; req1_r2 = b; req1_imm = im; req1_shamt = sh;
        end
    endtask

    // Spec-level model state for the traffic engine.
    int          cyc = 0;
    int          m_last, m_owner, m_due, gen_budget;
    bit          m_busy;
    logic [32:0] q0[$], q1[$];
    logic [31:0] rlog0[$], rlog1[$];
    int          grant_log[$];
    bit          p_v[2];
    logic [5:0]  p_cnt[2];
    logic [31:0] p_r1[2], p_r2[2], p_imm[2];
    logic [3:0]  p_sh[2];

    task automatic new_op(input int p);
        p_cnt[p] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                               : 6'(legal_codes[$urandom_range(0, 18)]);
        p_r1[p]  = $urandom;
        p_r2[p]  = ($urandom_range(0, 3) == 0) ? p_r1[p] : 32'($urandom);
        p_imm[p] = $urandom;
        p_sh[p]  = 4'($urandom_range(0, 15));
        p_v[p]   = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step(); cyc++;
        rst = 1'b0;
        m_last = 1; m_busy = 1'b0; m_owner = 0; m_due = 0;
        q0.delete(); q1.delete(); rlog0.delete(); rlog1.delete(); grant_log.delete();
        p_v[0] = 1'b0; p_v[1] = 1'b0;
    endtask

    // Cycle-by-cycle traffic checked against the arbitration and latency rules.
    task automatic run_traffic(input int n_cycles, input int gen_pct, input int rdy_pct);
        bit ev0, ev1, er0, er1, lg;
        int p;
        for (int k = 0; k < n_cycles; k++) begin
            ev0 = m_busy && (m_owner == 0) && (cyc >= m_due);
            ev1 = m_busy && (m_owner == 1) && (cyc >= m_due);
            chk("rsp0_valid", rsp0_valid, ev0);
            chk("rsp1_valid", rsp1_valid, ev1);
            chk("busy", busy, m_busy);
            if (ev0 && q0.size() > 0) chk("rsp0_data_err", {rsp0_err, rsp0_data}, q0[0]);
            if (ev1 && q1.size() > 0) chk("rsp1_data_err", {rsp1_err, rsp1_data}, q1[0]);
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i] && gen_budget > 0 && $urandom_range(0, 99) < gen_pct) begin
                    new_op(i);
                    gen_budget--;
                end
                set_req(i, p_v[i], p_cnt[i], p_r1[i], p_r2[i], p_imm[i], p_sh[i]);
            end
            rsp0_ready = ($urandom_range(0, 99) < rdy_pct);
            rsp1_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            er0 = !m_busy && p_v[0] && (!p_v[1] || m_last != 0);
            er1 = !m_busy && p_v[1] && (!p_v[0] || m_last != 1);
            chk("req0_ready", req0_ready, er0);
            chk("req1_ready", req1_ready, er1);
            if (ev0 && rsp0_ready) begin
                rlog0.push_back(rsp0_data);
                void'(q0.pop_front());
                m_busy = 1'b0;
            end
            if (ev1 && rsp1_ready) begin
                rlog1.push_back(rsp1_data);
                void'(q1.pop_front());
                m_busy = 1'b0;
            end
            if (er0 || er1) begin
                p  = er0 ? 0 : 1;
                lg = is_legal(p_cnt[p]);
                if (p == 0) q0.push_back({!lg, lg ? alu_fn(p_cnt[p], p_r1[p], p_r2[p], p_imm[p], p_sh[p]) : 32'd0});
                else        q1.push_back({!lg, lg ? alu_fn(p_cnt[p], p_r1[p], p_r2[p], p_imm[p], p_sh[p]) : 32'd0});
                grant_log.push_back(p);
                m_last  = p;
                m_owner = p;
                m_busy  = 1'b1;
                m_due   = cyc + (lg ? 2 : 1);
                p_v[p]  = 1'b0;
            end
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    // One directed operation from IDLE, with optional response stall and a competing request.
    task automatic do_op(input int p, input logic [5:0] c, input logic [31:0] a, b, im,
                         input logic [3:0] sh, input int stall, input bit other_v,
                         input logic [31:0] exp_d, input logic exp_e);
        bit lg;
        lg = is_legal(c);
        set_req(p, 1'b1, c, a, b, im, sh);
        #1;
        chk("op_ready", (p == 1) ? req1_ready : req0_ready, 1'b1);
        step();
        set_req(p, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        if (other_v) set_req(1 - p, 1'b1, 6'd1, 32'd1, 32'd1, 32'd0, 4'd0);
        chk("alu_cnt", alu_cnt, lg ? c : 6'd0);
        chk("alu_r1", alu_r1, a);
        chk("alu_r2", alu_r2, b);
        chk("alu_imm", alu_imm, im);
        chk("alu_shamt", alu_shamt, sh);
        if (lg) begin
            chk("exec_busy", busy, 1'b1);
            chk("exec_rsp_valid", (p == 1) ? rsp1_valid : rsp0_valid, 1'b0);
            step();
        end
        for (int k = 0; k <= stall; k++) begin
            if (p == 1) rsp1_ready = (k == stall); else rsp0_ready = (k == stall);
            #1;
            chk("op_rsp_valid", (p == 1) ? rsp1_valid : rsp0_valid, 1'b1);
            chk("op_rsp_data", (p == 1) ? rsp1_data : rsp0_data, exp_d);
            chk("op_rsp_err", (p == 1) ? rsp1_err : rsp0_err, exp_e);
            chk("op_other_valid", (p == 1) ? rsp0_valid : rsp1_valid, 1'b0);
            chk("op_busy", busy, 1'b1);
            chk("op_readys", {req0_ready, req1_ready}, 2'b00);
            step();
        end
        chk("op_done_valid", (p == 1) ? rsp1_valid : rsp0_valid, 1'b0);
        chk("op_done_busy", busy, 1'b0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        set_req(1 - p, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_cnt", alu_cnt, 6'd0);
        chk("rst_alu_r1", alu_r1, 32'd0);
        chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 4'd0);
        chk("rst_rsp_data", {rsp0_data, rsp1_data}, 64'd0);

        // Simultaneous SUB on port 0 and XOR on port 1 right after reset.
        p_v[0] = 1'b1; p_cnt[0] = 6'd2; p_r1[0] = 32'd10;  p_r2[0] = 32'd3;  p_imm[0] = 0; p_sh[0] = 0;
        p_v[1] = 1'b1; p_cnt[1] = 6'd6; p_r1[1] = 32'hF0;  p_r2[1] = 32'h0F; p_imm[1] = 0; p_sh[1] = 0;
        gen_budget = 0;
        run_traffic(12, 0, 100);
        chk("pair_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) chk("pair_order", {grant_log[0][1:0], grant_log[1][1:0]}, 4'b0001);
        chk("pair_rsp_counts", {rlog0.size(), rlog1.size()}, {32'd1, 32'd1});
        if (rlog0.size() > 0) chk("sub_result", rlog0[0], 32'd7);
        if (rlog1.size() > 0) chk("xor_result", rlog1[0], 32'hFF);

        // Both ports continuously valid for six operations.
        do_reset();
        new_op(0); new_op(1);
        gen_budget = 4;
        run_traffic(30, 100, 100);
        chk("alt_grants", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size(); i++) chk("alt_order", grant_log[i], i % 2);
        chk("alt_drained", q0.size() + q1.size(), 0);

        // Directed ADD, stalled BEQ, illegal code.
        do_reset();
        do_op(0, 6'd1, 32'd5, 32'd7, 32'd0, 4'd0, 0, 1'b0, 32'd12, 1'b0);
        do_op(1, 6'd27, 32'd9, 32'd9, 32'd0, 4'd0, 3, 1'b1, 32'd1, 1'b0);
        do_op(0, 6'd5, 32'h1234, 32'h55, 32'h7, 4'd3, 1, 1'b0, 32'd0, 1'b1);

        // Reset in the middle of EXEC discards the operation.
        set_req(0, 1'b1, 6'd1, 32'd100, 32'd23, 32'd0, 4'd0);
        rsp0_ready = 1'b1;
        #1;
        chk("rx_ready", req0_ready, 1'b1);
        step();
        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        chk("rx_exec_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rx_rsp0_valid", rsp0_valid, 1'b0);
        chk("rx_busy", busy, 1'b0);
        chk("rx_alu", {alu_cnt, alu_r1}, 38'd0);
        set_req(0, 1'b1, 6'd3, 32'hA, 32'hB, 32'd0, 4'd0);
        set_req(1, 1'b1, 6'd4, 32'hC, 32'hD, 32'd0, 4'd0);
        #1;
        chk("rx_grant", {req0_ready, req1_ready}, 2'b10);
        step();
        chk("rx_rsp0_still_low", rsp0_valid, 1'b0);
        chk("rx_alu_cnt", alu_cnt, 6'd3);

        // Randomized traffic, then drain.
        do_reset();
        gen_budget = 150;
        run_traffic(700, 50, 60);
        gen_budget = 0;
        run_traffic(40, 0, 100);
        chk("rand_drained", q0.size() + q1.size() + int'(m_busy) + int'(p_v[0]) + int'(p_v[1]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
